// File: rtl/nf10_sram_oq_scheduler.sv
// Output-queue read scheduler: round-robin grant of one stored packet at a time
// to the SRAM read engine, with per-queue saturating packet counters.
//
// state | meaning
// IDLE  | arbitrate among eligible queues (count != 0 and downstream space)
// REQ   | rd_req asserted for the committed grant, waiting for rd_ack
// XFER  | packet being read out, waiting for rd_done (tlast)
module nf10_sram_oq_scheduler #(
  parameter int NUM_QUEUES     = 5,
  parameter int QUEUE_ID_WIDTH = 3,
  parameter int PKT_CNT_WIDTH  = 12
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                enq_valid,
  input  logic [QUEUE_ID_WIDTH-1:0]           enq_queue,
  input  logic [NUM_QUEUES-1:0]               deq_allow,
  output logic                                rd_req,
  output logic [QUEUE_ID_WIDTH-1:0]           rd_queue,
  input  logic                                rd_ack,
  input  logic                                rd_done,
  output logic [NUM_QUEUES*PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                                busy,
  output logic                                err_overflow
);

  localparam int CW = QUEUE_ID_WIDTH + 1;
  localparam logic [CW-1:0] NQ = CW'(NUM_QUEUES);
  localparam logic [QUEUE_ID_WIDTH-1:0] LAST_Q = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
  localparam logic [PKT_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_e;

  state_e                    state_q, state_d;
  logic [QUEUE_ID_WIDTH-1:0] grant_q, grant_d;
  logic [QUEUE_ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [PKT_CNT_WIDTH-1:0]  cnt_q [NUM_QUEUES];
  logic [PKT_CNT_WIDTH-1:0]  cnt_d [NUM_QUEUES];
  logic                      err_q, err_d;
  logic [NUM_QUEUES-1:0]     elig, inc_v, dec_v;
  logic                      found;
  logic [QUEUE_ID_WIDTH-1:0] pick;
  logic [CW-1:0]             cand;
  logic                      enq_ok, ack_fire;

  assign enq_ok   = enq_valid && ({1'b0, enq_queue} < NQ);
  assign ack_fire = (state_q == ST_REQ) && rd_ack;

  always_comb begin
    elig  = '0;
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      elig[i]  = (cnt_q[i] != '0) && deq_allow[i];
      inc_v[i] = enq_ok && (enq_queue == QUEUE_ID_WIDTH'(i));
      dec_v[i] = ack_fire && (grant_q == QUEUE_ID_WIDTH'(i));
    end
  end

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      cand = {1'b0, last_grant_q} + CW'(k);
      if (cand >= NQ) cand = cand - NQ;
      if (!found && elig[cand[QUEUE_ID_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = cand[QUEUE_ID_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_Q;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: if (found) begin
        state_d = ST_REQ;
        grant_d = pick;
      end
      ST_REQ:  if (rd_ack) state_d = ST_XFER;
      ST_XFER: if (rd_done) begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req   = (state_q == ST_REQ);
    busy     = (state_q != ST_IDLE);
    rd_queue = grant_q;
  end

  // Simultaneous enqueue and dequeue on one queue cancel out.
  always_comb begin
    err_d = err_q;
    if (enq_valid && !enq_ok) err_d = 1'b1;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] + PKT_CNT_WIDTH'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - PKT_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_q <= 1'b0;
      for (int i = 0; i < NUM_QUEUES; i++) cnt_q[i] <= '0;
    end else begin
      err_q <= err_d;
      for (int i = 0; i < NUM_QUEUES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      pkt_count[i*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] = cnt_q[i];
  end

  assign err_overflow = err_q;

endmodule

// File: tb/tb_nf10_sram_oq_scheduler.sv
// Bench for nf10_sram_oq_scheduler: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_nf10_sram_oq_scheduler;

  localparam int NQ   = 5;
  localparam int QW   = 3;
  localparam int CWID = 12;
  localparam int MAXC = 4095;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic             enq_valid = 1'b0;
  logic [QW-1:0]    enq_queue = '0;
  logic [NQ-1:0]    deq_allow = '1;
  logic             rd_ack = 1'b0;
  logic             rd_done = 1'b0;
  logic             rd_req, busy, err_overflow;
  logic [QW-1:0]    rd_queue;
  logic [NQ*CWID-1:0] pkt_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet counts, whether a packet is requested/in flight, and rotation pointer.
  int m_cnt [NQ];
  int m_phase;   // 0 no packet, 1 requested, 2 transferring
  int m_grant;
  int m_last;
  bit m_err;

  nf10_sram_oq_scheduler dut (
    .aclk(aclk), .areset(areset), .enq_valid(enq_valid), .enq_queue(enq_queue),
    .deq_allow(deq_allow), .rd_req(rd_req), .rd_queue(rd_queue), .rd_ack(rd_ack),
    .rd_done(rd_done), .pkt_count(pkt_count), .busy(busy), .err_overflow(err_overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_pick();
    int q;
    for (int k = 1; k <= NQ; k++) begin
      q = (m_last + k) % NQ;
      if (m_cnt[q] > 0 && deq_allow[q]) return q;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) m_cnt[q] = 0;
    m_phase = 0;
    m_grant = 0;
    m_last  = NQ - 1;
    m_err   = 1'b0;
  endtask

  task automatic model_update();
    int pick;
    int dq;
    bit inc;
    dq = -1;
    case (m_phase)
      0: begin
        pick = rr_pick();
        if (pick >= 0) begin
          m_grant = pick;
          m_phase = 1;
        end
      end
      1: if (rd_ack) begin
        dq = m_grant;
        m_phase = 2;
      end
      default: if (rd_done) begin
        m_last = m_grant;
        m_phase = 0;
      end
    endcase
    for (int q = 0; q < NQ; q++) begin
      inc = enq_valid && (int'(enq_queue) == q);
      if (inc && q != dq) begin
        if (m_cnt[q] == MAXC) m_err = 1'b1;
        else m_cnt[q] = m_cnt[q] + 1;
      end else if (!inc && q == dq) begin
        m_cnt[q] = m_cnt[q] - 1;
      end
    end
    if (enq_valid && int'(enq_queue) >= NQ) m_err = 1'b1;
  endtask

  task automatic check_model();
    check_eq("rd_req", rd_req, m_phase == 1);
    check_eq("busy", busy, m_phase != 0);
    if (m_phase == 1) check_eq("rd_queue", rd_queue, m_grant);
    for (int q = 0; q < NQ; q++)
      check_eq($sformatf("pkt_count%0d", q), pkt_count[q*CWID +: CWID], m_cnt[q]);
    check_eq("err_overflow", err_overflow, m_err);
  endtask

  task automatic cycle();
    @(posedge aclk);
    model_update();
    @(negedge aclk);
    check_model();
  endtask

  // Called just after a falling edge; reset takes effect without a clock.
  task automatic do_reset();
    areset = 1'b1;
    #1;
    model_reset();
    check_model();
    check_eq("rst_rd_queue", rd_queue, 0);
    #1;
    areset = 1'b0;
  endtask

  task automatic enq(input int q);
    enq_valid = 1'b1;
    enq_queue = QW'(q);
    cycle();
    enq_valid = 1'b0;
  endtask

  task automatic wait_req(input int exp, output int n);
    n = 0;
    while (!rd_req && n < 20) begin
      cycle();
      n++;
    end
    check_eq("req_seen", rd_req, 1);
    check_eq("grant", rd_queue, exp);
  endtask

  task automatic serve(input int exp);
    int n;
    wait_req(exp, n);
    rd_ack = 1'b1;
    cycle();
    rd_ack = 1'b0;
    rd_done = 1'b1;
    cycle();
    rd_done = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    @(negedge aclk);
    do_reset();

    // single packet through q2
    enq(2);
    check_eq("q2_cnt_after_enq", pkt_count[2*CWID +: CWID], 1);
    wait_req(2, n);
    check_eq("q2_latency", n, 1);
    rd_ack = 1'b1; cycle(); rd_ack = 1'b0;
    check_eq("q2_cnt_after_ack", pkt_count[2*CWID +: CWID], 0);
    check_eq("q2_busy_xfer", busy, 1);
    rd_done = 1'b1; cycle(); rd_done = 1'b0;
    check_eq("q2_busy_done", busy, 0);

    // round-robin order 0,1,4 then 0,3
    do_reset();
    deq_allow = '0;
    enq(0); enq(1); enq(4);
    deq_allow = '1;
    serve(0); serve(1); serve(4);
    deq_allow = '0;
    enq(0); enq(3);
    deq_allow = '1;
    serve(0); serve(3);

    // blocked queue skipped until downstream space returns
    do_reset();
    deq_allow = '0;
    enq(1); enq(1); enq(1); enq(3);
    deq_allow = 5'b11101;
    serve(3);
    repeat (5) begin
      cycle();
      check_eq("blocked_no_req", rd_req, 0);
    end
    deq_allow = '1;
    serve(1); serve(1); serve(1);

    // committed grant holds while rd_ack is withheld
    enq(2);
    wait_req(2, n);
    deq_allow[2] = 1'b0;
    repeat (10) begin
      cycle();
      check_eq("hold_req", rd_req, 1);
      check_eq("hold_queue", rd_queue, 2);
      check_eq("hold_cnt", pkt_count[2*CWID +: CWID], 1);
    end
    rd_ack = 1'b1; cycle(); rd_ack = 1'b0;
    check_eq("hold_cnt_ack", pkt_count[2*CWID +: CWID], 0);
    rd_done = 1'b1; cycle(); rd_done = 1'b0;
    deq_allow = '1;

    // enqueue coinciding with dequeue on the same queue
    deq_allow = '0;
    enq(0); enq(0);
    deq_allow = '1;
    wait_req(0, n);
    rd_ack = 1'b1; enq_valid = 1'b1; enq_queue = 3'd0;
    cycle();
    rd_ack = 1'b0; enq_valid = 1'b0;
    check_eq("coalesce_cnt", pkt_count[0 +: CWID], 2);
    rd_done = 1'b1; cycle(); rd_done = 1'b0;

    // saturation
    do_reset();
    deq_allow = '0;
    enq_valid = 1'b1; enq_queue = 3'd1;
    repeat (MAXC) cycle();
    check_eq("sat_cnt_full", pkt_count[CWID +: CWID], MAXC);
    check_eq("sat_err_before", err_overflow, 0);
    cycle();
    enq_valid = 1'b0;
    check_eq("sat_cnt_held", pkt_count[CWID +: CWID], MAXC);
    check_eq("sat_err_after", err_overflow, 1);

    // out-of-range queue index
    do_reset();
    enq(6);
    check_eq("oor_err", err_overflow, 1);
    check_eq("oor_cnt", pkt_count, 0);
    repeat (3) cycle();
    check_eq("oor_err_sticky", err_overflow, 1);

    // reset during transfer, then stale rd_done
    do_reset();
    deq_allow = '1;
    enq(4);
    wait_req(4, n);
    rd_ack = 1'b1; cycle(); rd_ack = 1'b0;
    check_eq("xfer_busy", busy, 1);
    do_reset();
    check_eq("xfer_rst_busy", busy, 0);
    rd_done = 1'b1; cycle(); rd_done = 1'b0;
    check_eq("stale_done_busy", busy, 0);
    check_eq("stale_done_req", rd_req, 0);
    repeat (3) cycle();

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enq_valid = ($urandom_range(0, 2) == 0);
      enq_queue = ($urandom_range(0, 39) == 0) ? QW'($urandom_range(5, 7)) : QW'($urandom_range(0, 4));
      deq_allow = NQ'($urandom);
      rd_ack    = ($urandom_range(0, 2) == 0);
      rd_done   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 699) == 0) do_reset();
      cycle();
    end
    enq_valid = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
